pattern_det: RTL and testbench

- Parametrised serial bit-pattern detector for single-bit input streams.
- Pattern, care-mask, length and overlap mode are programmable at run time; the block is armed and disarmed by pulses.
- Registered one-cycle match pulse plus a saturating match counter.
- Sits on serial control/sync paths where fixed-pattern detectors were hard-coded per use.

---
 rtl/pattern_det_pkg.sv | 20 ++
 rtl/pattern_det_sat_counter.sv | 30 +++
 rtl/pattern_det.sv | 124 ++++++++++++
 tb/tb_pattern_det.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types, reset-time configuration defaults and the length-mask helper for pattern_det.
package pattern_det_pkg;

  typedef enum logic [0:0] {StDisarmed, StArmed} state_e;

  localparam logic [31:0] DefPattern = 32'h0000_0000;
  localparam logic [31:0] DefMask    = 32'hffff_ffff;
  localparam logic        DefOverlap = 1'b1;

  // Low len bits set; callers truncate to their pattern width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pattern_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pattern_det.sv
// Programmable serial bit-pattern detector: masked compare over the last len valid bits,
// optional overlap, armed/disarmed by pulses, registered match pulse and saturating count.
module pattern_det
  import pattern_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             arm,
  input  logic             disarm,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, mask_q, mask_d, hist_q, hist_d, hist_n;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_n;
  logic             ovl_q, ovl_d, match_q, match_d, err_q, err_d;
  logic             cfg_ok, hit;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LenMax);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    err_d   = 1'b0;

    // Candidate history/fill as if din were accepted this cycle.
    hist_n = PAT_W'({hist_q, din});
    fill_n = (fill_q == LenMax) ? fill_q : fill_q + 1'b1;
    hit    = (fill_n >= len_q) &&
             (((hist_n ^ pat_q) & mask_q & PAT_W'(len_mask(32'(len_q)))) == '0);

    case (state_q)
      StDisarmed: begin
        if (cfg_we) begin
          if (cfg_ok) begin
            pat_d  = cfg_pattern;
            mask_d = cfg_mask;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
          end else begin
            err_d = 1'b1;
          end
        end
        if (arm && !disarm) begin
          state_d = StArmed;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
      StArmed: begin
        // A completing bit still matches even if disarm arrives in the same cycle.
        if (din_valid) begin
          hist_d  = hist_n;
          fill_d  = (hit && !ovl_q) ? '0 : fill_n;
          match_d = hit;
        end
        if (disarm) state_d = StDisarmed;
      end
      default: state_d = StDisarmed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StDisarmed;
      pat_q   <= PAT_W'(DefPattern);
      mask_q  <= PAT_W'(DefMask);
      len_q   <= LenMax;
      ovl_q   <= DefOverlap;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match_d),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

  assign armed   = (state_q == StArmed);
  assign match   = match_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_pattern_det.sv
// Directed plus randomized bench for pattern_det, checked against a bit-queue reference model.
module tb_pattern_det;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, din, din_valid, cfg_we, cfg_overlap, arm, disarm, cnt_clr;
  logic [PAT_W-1:0] cfg_pattern, cfg_mask;
  logic [LEN_W-1:0] cfg_len;
  logic             armed, match, cfg_err;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  pattern_det #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .arm        (arm),
    .disarm     (disarm),
    .cnt_clr    (cnt_clr),
    .armed      (armed),
    .match      (match),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the valid bits seen since arming (or since the last non-overlapping match).
  bit          mq[$];
  bit          m_armed, m_match, m_err, m_ovl;
  int unsigned m_cnt, m_len;
  bit [PAT_W-1:0] m_pat, m_mask;

  function automatic bit model_hit();
    if (mq.size() < m_len) return 1'b0;
    for (int i = 0; i < int'(m_len); i++) begin
      if (m_mask[i] && (mq[mq.size() - 1 - i] != m_pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit nm;
    nm = 1'b0;
    if (!rst) begin
      m_armed = 0; m_match = 0; m_err = 0; m_cnt = 0;
      m_pat = '0; m_mask = '1; m_len = PAT_W; m_ovl = 1;
      mq.delete();
      return;
    end
    m_err = 1'b0;
    if (!m_armed && cfg_we) begin
      if (cfg_len >= 1 && cfg_len <= PAT_W) begin
        m_pat = cfg_pattern; m_mask = cfg_mask; m_len = cfg_len; m_ovl = cfg_overlap;
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_armed && din_valid) begin
      mq.push_back(din);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      if (model_hit()) begin
        nm = 1'b1;
        if (!m_ovl) mq.delete();
      end
    end
    if (!m_armed) begin
      if (arm && !disarm) begin
        m_armed = 1'b1;
        mq.delete();
      end
    end else if (disarm) begin
      m_armed = 1'b0;
    end
    if (cnt_clr) m_cnt = 0;
    else if (nm && m_cnt < CMAX) m_cnt++;
    m_match = nm;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("armed", armed, m_armed);
    check_eq("match", match, m_match);
    check_eq("match_cnt", match_cnt, m_cnt);
    check_eq("cfg_err", cfg_err, m_err);
    cfg_we = 0; arm = 0; disarm = 0; cnt_clr = 0; din_valid = 0; rst = 1;
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                        input logic [LEN_W-1:0] l, input logic o);
    cfg_we = 1; cfg_pattern = p; cfg_mask = m; cfg_len = l; cfg_overlap = o;
    tick();
  endtask

  task automatic bit_in(input logic b);
    din = b; din_valid = 1;
    tick();
  endtask

  task automatic do_arm();    arm = 1;    tick(); endtask
  task automatic do_disarm(); disarm = 1; tick(); endtask
  task automatic do_clr();    cnt_clr = 1; tick(); endtask

  initial begin
    rst = 0; din = 0; din_valid = 0; cfg_we = 0; cfg_overlap = 0; arm = 0; disarm = 0;
    cnt_clr = 0; cfg_pattern = '0; cfg_mask = '0; cfg_len = '0;
    tick();
    check_eq("rst_armed", armed, 0);
    check_eq("rst_cnt", match_cnt, 0);

    // 101 overlapping over 1,0,1,0,1
    do_cfg(8'b101, 8'hff, 4'd3, 1'b1);
    do_arm();
    bit_in(1); bit_in(0); bit_in(1);
    check_eq("t1_match_b3", match, 1);
    bit_in(0); bit_in(1);
    check_eq("t1_match_b5", match, 1);
    check_eq("t1_cnt", match_cnt, 2);

    // same, non-overlapping
    do_disarm(); do_clr();
    do_cfg(8'b101, 8'hff, 4'd3, 1'b0);
    do_arm();
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    check_eq("t2_cnt", match_cnt, 1);

    // 11010 with gaps
    do_disarm(); do_clr();
    do_cfg(8'b11010, 8'hff, 4'd5, 1'b1);
    do_arm();
    bit_in(1); tick(); bit_in(1); tick(); bit_in(0); tick(); bit_in(1); tick(); tick();
    check_eq("t3_early", match, 0);
    bit_in(0);
    check_eq("t3_match", match, 1);
    tick();
    check_eq("t3_pulse_end", match, 0);
    check_eq("t3_cnt", match_cnt, 1);

    // illegal len rejected, old config kept; cfg while armed ignored
    do_disarm();
    do_cfg(8'h00, 8'h00, 4'd0, 1'b1);
    check_eq("t4_err", cfg_err, 1);
    do_cfg(8'h00, 8'h00, 4'd9, 1'b1);
    do_arm();
    do_cfg(8'h00, 8'h00, 4'd1, 1'b1);
    check_eq("t4_armed_noerr", cfg_err, 0);
    bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    check_eq("t4_old_cfg", match, 1);

    // saturation and clear-wins
    do_disarm(); do_clr();
    do_cfg(8'h00, 8'h00, 4'd1, 1'b1);
    do_arm();
    for (int i = 0; i < 10; i++) bit_in(1'($urandom));
    check_eq("t5_sat", match_cnt, CMAX);
    cnt_clr = 1;
    bit_in(1);
    check_eq("t5_clr_match", match, 1);
    check_eq("t5_clr_wins", match_cnt, 0);

    // mid-pattern reset and mid-pattern arm+disarm
    do_disarm();
    do_cfg(8'b11010, 8'hff, 4'd5, 1'b1);
    do_arm();
    bit_in(1); bit_in(1); bit_in(0);
    tick();  // rst=0 applied by clearing below
    rst = 0; tick();
    do_cfg(8'b11010, 8'hff, 4'd5, 1'b1);
    do_arm();
    bit_in(1); bit_in(0);
    check_eq("t6_rst_nomatch", match, 0);
    bit_in(1); bit_in(1); bit_in(0);
    arm = 1; disarm = 1; tick();
    check_eq("t6_armdis", armed, 0);
    do_arm();
    bit_in(1); bit_in(0);
    check_eq("t6_hist_dropped", match, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 299) != 0);
      din         = 1'($urandom);
      din_valid   = ($urandom_range(0, 9) < 7);
      arm         = ($urandom_range(0, 19) == 0);
      disarm      = ($urandom_range(0, 39) == 0);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      cfg_we      = ($urandom_range(0, 14) == 0);
      cfg_pattern = 8'($urandom);
      cfg_mask    = ($urandom_range(0, 1) != 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
